// File: rtl/pc_pkg.sv
// Shared types, constants and helpers for the IF-stage PC / branch target buffer.
package pc_pkg;

  // Widest PC supported by the BTB entry layout; narrower PCs are zero-extended.
  localparam int XLEN_MAX   = 64;
  localparam int INST_BYTES = 4;

  // Two-bit saturating direction counter encodings.
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [XLEN_MAX-1:0] tag;
    logic [XLEN_MAX-1:0] target;
    logic [1:0]          ctr;
  } btb_entry_t;

  // Saturating counter step toward taken / not-taken.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end else begin
      res = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-PC control bundle: hazard/stall controls, EX redirect, BTB update, fetch outputs.
interface pc_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            stall_i;
  logic            pc_write_i;
  logic            redirect_valid_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            btb_upd_valid_i;
  logic [XLEN-1:0] btb_upd_pc_i;
  logic [XLEN-1:0] btb_upd_target_i;
  logic            btb_upd_taken_i;
  logic [XLEN-1:0] pc_o;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_target_o;
  logic            redirect_pending_o;

  // The fetch unit itself.
  modport slave (
    input  stall_i, pc_write_i, redirect_valid_i, redirect_pc_i,
    input  btb_upd_valid_i, btb_upd_pc_i, btb_upd_target_i, btb_upd_taken_i,
    output pc_o, pred_taken_o, pred_target_o, redirect_pending_o
  );

  // The pipeline control side driving the fetch unit.
  modport master (
    output stall_i, pc_write_i, redirect_valid_i, redirect_pc_i,
    output btb_upd_valid_i, btb_upd_pc_i, btb_upd_target_i, btb_upd_taken_i,
    input  pc_o, pred_taken_o, pred_target_o, redirect_pending_o
  );
endinterface

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// registered update from resolved EX branches with 2-bit saturating counters.
module pc_btb
  import pc_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lk_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i
);

  btb_entry_t          mem_q [BTB_ENTRIES];
  btb_entry_t          lk_ent;
  btb_entry_t          upd_ent;
  btb_entry_t          upd_ent_d;
  logic                upd_wr;
  logic [IDX_W-1:0]    lk_idx;
  logic [IDX_W-1:0]    upd_idx;
  logic [XLEN_MAX-1:0] lk_tag;
  logic [XLEN_MAX-1:0] upd_tag;
  logic [XLEN_MAX-1:0] upd_tgt;
  logic                lk_hit;
  logic                upd_hit;
  logic                unused_bits;

  assign lk_idx  = lk_pc_i[IDX_W+1:2];
  assign lk_tag  = XLEN_MAX'(lk_pc_i[XLEN-1:IDX_W+2]);
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = XLEN_MAX'(upd_pc_i[XLEN-1:IDX_W+2]);
  // Targets are always word aligned; low bits of the resolved target are dropped.
  assign upd_tgt = XLEN_MAX'({upd_target_i[XLEN-1:2], 2'b00});

  // Lookup reads the array before this cycle's update lands.
  assign lk_ent        = mem_q[lk_idx];
  assign lk_hit        = lk_ent.valid && (lk_ent.tag == lk_tag);
  assign pred_taken_o  = lk_hit & lk_ent.ctr[1];
  assign pred_target_o = pred_taken_o ? lk_ent.target[XLEN-1:0] : '0;

  assign upd_ent = mem_q[upd_idx];
  assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

  assign unused_bits = ^{lk_pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0],
                         lk_ent.ctr[0], lk_ent.target >> XLEN};

  // Build the replacement entry: train on hit, allocate on taken miss.
  always_comb begin
    upd_wr    = 1'b0;
    upd_ent_d = upd_ent;
    if (upd_valid_i) begin
      if (upd_hit) begin
        upd_wr        = 1'b1;
        upd_ent_d.ctr = ctr_next(upd_ent.ctr, upd_taken_i);
        if (upd_taken_i) begin
          upd_ent_d.target = upd_tgt;
        end
      end else if (upd_taken_i) begin
        upd_wr           = 1'b1;
        upd_ent_d.valid  = 1'b1;
        upd_ent_d.tag    = upd_tag;
        upd_ent_d.target = upd_tgt;
        upd_ent_d.ctr    = CTR_WT;
      end
    end
  end

  // BTB storage; reset invalidates every entry and parks counters weakly not-taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        mem_q[i].valid <= 1'b0;
        mem_q[i].ctr   <= CTR_WNT;
      end
    end else if (upd_wr) begin
      mem_q[upd_idx] <= upd_ent_d;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage fetch PC: PC register, pending-redirect buffer and next-PC priority mux
// (live redirect > pending redirect > BTB prediction > PC+4).
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input logic               clk,
  input logic               rst_n,
  pc_fetch_unit_if.slave    fetch_if
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            pend_vld_q;
  logic            pend_vld_d;
  logic [XLEN-1:0] pend_pc_q;
  logic [XLEN-1:0] pend_pc_d;
  logic            adv;
  logic [XLEN-1:0] redir_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            unused_bits;

  assign adv         = fetch_if.pc_write_i & ~fetch_if.stall_i;
  assign redir_pc    = {fetch_if.redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_bits = ^fetch_if.redirect_pc_i[1:0];

  pc_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_btb (
    .clk           (clk),
    .rst_n         (rst_n),
    .lk_pc_i       (pc_q),
    .pred_taken_o  (pred_taken),
    .pred_target_o (pred_target),
    .upd_valid_i   (fetch_if.btb_upd_valid_i),
    .upd_pc_i      (fetch_if.btb_upd_pc_i),
    .upd_target_i  (fetch_if.btb_upd_target_i),
    .upd_taken_i   (fetch_if.btb_upd_taken_i)
  );

  // Next-PC selection and pending-redirect bookkeeping.
  always_comb begin
    pc_d       = pc_q;
    pend_vld_d = pend_vld_q;
    pend_pc_d  = pend_pc_q;
    if (adv) begin
      // Any advancing cycle drains the buffer: it is either used now or
      // made stale by a live redirect that wins the mux.
      pend_vld_d = 1'b0;
      if (fetch_if.redirect_valid_i) begin
        pc_d = redir_pc;
      end else if (pend_vld_q) begin
        pc_d = pend_pc_q;
      end else if (pred_taken) begin
        pc_d = pred_target;
      end else begin
        pc_d = pc_q + XLEN'(INST_BYTES);
      end
    end else if (fetch_if.redirect_valid_i) begin
      // Frozen PC: hold the newest redirect until the pipeline moves.
      pend_vld_d = 1'b1;
      pend_pc_d  = redir_pc;
    end
  end

  // PC and pending-redirect registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_VEC;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  assign fetch_if.pc_o               = pc_q;
  assign fetch_if.pred_taken_o       = pred_taken;
  assign fetch_if.pred_target_o      = pred_target;
  assign fetch_if.redirect_pending_o = pend_vld_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Table-driven bench for pc_fetch_unit with an expected-result queue.
module tb_pc_fetch_unit;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct packed {
    logic        rst_n;
    logic        stall;
    logic        pcw;
    logic        rv;
    logic [31:0] rpc;
    logic        uv;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        utk;
    logic [31:0] epc;
    logic        ept;
    logic [31:0] etgt;
    logic        epend;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
    logic        pend;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   nvec = 0;
  int   nmis = 0;
  int   ncmp = 0;
  vec_t tbl[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pc_fetch_unit_if #(.XLEN(32)) bus ();

  pc_fetch_unit #(
    .XLEN        (32),
    .RESET_VEC   (32'h0000_0000),
    .BTB_ENTRIES (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fetch_if (bus)
  );

  function automatic vec_t V(input logic r, input logic st, input logic pw, input logic rv,
                             input logic [31:0] rpc, input logic uv, input logic [31:0] upc,
                             input logic [31:0] utgt, input logic utk, input logic [31:0] epc,
                             input logic ept, input logic [31:0] etgt, input logic epend);
    vec_t v;
    v.rst_n = r;   v.stall = st;  v.pcw = pw;   v.rv = rv;   v.rpc = rpc;
    v.uv = uv;     v.upc = upc;   v.utgt = utgt; v.utk = utk;
    v.epc = epc;   v.ept = ept;   v.etgt = etgt; v.epend = epend;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    ncmp++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s at vector %0d: got %h, want %h", nm, nvec, act, want);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst_n                = v.rst_n;
    bus.stall_i          = v.stall;
    bus.pc_write_i       = v.pcw;
    bus.redirect_valid_i = v.rv;
    bus.redirect_pc_i    = v.rpc;
    bus.btb_upd_valid_i  = v.uv;
    bus.btb_upd_pc_i     = v.upc;
    bus.btb_upd_target_i = v.utgt;
    bus.btb_upd_taken_i  = v.utk;
    exp_q.push_back('{pc: v.epc, pt: v.ept, tgt: v.etgt, pend: v.epend});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    nvec++;
    chk("pc_o", bus.pc_o, e.pc);
    chk("pred_taken_o", {31'b0, bus.pred_taken_o}, {31'b0, e.pt});
    chk("pred_target_o", bus.pred_target_o, e.tgt);
    chk("redirect_pending_o", {31'b0, bus.redirect_pending_o}, {31'b0, e.pend});
  endtask

  initial begin
    rst_n                = 1'b0;
    bus.stall_i          = 1'b0;
    bus.pc_write_i       = 1'b0;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i    = '0;
    bus.btb_upd_valid_i  = 1'b0;
    bus.btb_upd_pc_i     = '0;
    bus.btb_upd_target_i = '0;
    bus.btb_upd_taken_i  = 1'b0;

    //          rst st pw rv rpc            uv upc     utgt    utk  pc             pt tgt    pend
    // reset and sequential fetch on an empty BTB
    tbl.push_back(V(L, L, L, L, 32'h0,   L, 32'h0,   32'h0,   L, 32'h0,   L, 32'h0,   L));
    tbl.push_back(V(H, L, H, L, 32'h0,   L, 32'h0,   32'h0,   L, 32'h4,   L, 32'h0,   L));
    tbl.push_back(V(H, L, H, L, 32'h0,   L, 32'h0,   32'h0,   L, 32'h8,   L, 32'h0,   L));
    tbl.push_back(V(H, L, H, L, 32'h0,   L, 32'h0,   32'h0,   L, 32'hC,   L, 32'h0,   L));
    // redirect under stall is buffered, then consumed
    tbl.push_back(V(H, H, H, H, 32'h100, L, 32'h0,   32'h0,   L, 32'hC,   L, 32'h0,   H));
    tbl.push_back(V(H, L, H, L, 32'h0,   L, 32'h0,   32'h0,   L, 32'h100, L, 32'h0,   L));
    // newer buffered redirect wins
    tbl.push_back(V(H, H, H, H, 32'h200, L, 32'h0,   32'h0,   L, 32'h100, L, 32'h0,   H));
    tbl.push_back(V(H, H, H, H, 32'h300, L, 32'h0,   32'h0,   L, 32'h100, L, 32'h0,   H));
    tbl.push_back(V(H, L, H, L, 32'h0,   L, 32'h0,   32'h0,   L, 32'h300, L, 32'h0,   L));
    // pc_write low holds the PC
    tbl.push_back(V(H, L, L, L, 32'h0,   L, 32'h0,   32'h0,   L, 32'h300, L, 32'h0,   L));
    // allocate 0x40->0x80 (same index as 0x300, different tag: no hit there)
    tbl.push_back(V(H, H, H, L, 32'h0,   H, 32'h40,  32'h80,  H, 32'h300, L, 32'h0,   L));
    tbl.push_back(V(H, L, H, H, 32'h40,  L, 32'h0,   32'h0,   L, 32'h40,  H, 32'h80,  L));
    tbl.push_back(V(H, L, H, L, 32'h0,   L, 32'h0,   32'h0,   L, 32'h80,  L, 32'h0,   L));
    // train not-taken twice: 10 -> 01 -> 00
    tbl.push_back(V(H, H, H, L, 32'h0,   H, 32'h40,  32'h0,   L, 32'h80,  L, 32'h0,   L));
    tbl.push_back(V(H, H, H, H, 32'h40,  H, 32'h40,  32'h0,   L, 32'h80,  L, 32'h0,   H));
    tbl.push_back(V(H, L, H, L, 32'h0,   L, 32'h0,   32'h0,   L, 32'h40,  L, 32'h0,   L));
    tbl.push_back(V(H, L, H, L, 32'h0,   L, 32'h0,   32'h0,   L, 32'h44,  L, 32'h0,   L));
    // train taken twice: 00 -> 01 -> 10
    tbl.push_back(V(H, L, L, L, 32'h0,   H, 32'h40,  32'h80,  H, 32'h44,  L, 32'h0,   L));
    tbl.push_back(V(H, L, L, L, 32'h0,   H, 32'h40,  32'h80,  H, 32'h44,  L, 32'h0,   L));
    tbl.push_back(V(H, L, H, H, 32'h40,  L, 32'h0,   32'h0,   L, 32'h40,  H, 32'h80,  L));
    // live redirect beats a BTB hit
    tbl.push_back(V(H, L, H, H, 32'h500, L, 32'h0,   32'h0,   L, 32'h500, L, 32'h0,   L));
    tbl.push_back(V(H, L, H, H, 32'h40,  L, 32'h0,   32'h0,   L, 32'h40,  H, 32'h80,  L));
    // taken hit rewrites target, visible next cycle
    tbl.push_back(V(H, H, H, L, 32'h0,   H, 32'h40,  32'hC0,  H, 32'h40,  H, 32'hC0,  L));
    // update and lookup collide: this cycle's fetch uses the old target
    tbl.push_back(V(H, L, H, L, 32'h0,   H, 32'h40,  32'h100, H, 32'hC0,  L, 32'h0,   L));
    // low bits of redirect and update target are dropped
    tbl.push_back(V(H, L, H, H, 32'h603, L, 32'h0,   32'h0,   L, 32'h600, L, 32'h0,   L));
    tbl.push_back(V(H, H, H, L, 32'h0,   H, 32'h600, 32'h707, H, 32'h600, H, 32'h704, L));
    // not-taken miss leaves the entry alone
    tbl.push_back(V(H, H, H, L, 32'h0,   H, 32'h40,  32'h0,   L, 32'h600, H, 32'h704, L));
    tbl.push_back(V(H, L, H, L, 32'h0,   L, 32'h0,   32'h0,   L, 32'h704, L, 32'h0,   L));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
    end

    // PC+4 wraps at the top of the address space
    step(V(H, L, H, H, 32'hFFFF_FFFC, L, 32'h0, 32'h0, L, 32'hFFFF_FFFC, L, 32'h0, L));
    step(V(H, L, H, L, 32'h0,         L, 32'h0, 32'h0, L, 32'h0,         L, 32'h0, L));

    // reset while a redirect is pending and the BTB holds a valid entry
    step(V(H, L, H, L, 32'h0,   L, 32'h0, 32'h0, L, 32'h4,   L, 32'h0, L));
    step(V(H, H, H, H, 32'h900, L, 32'h0, 32'h0, L, 32'h4,   L, 32'h0, H));
    step(V(L, H, H, H, 32'hA00, L, 32'h0, 32'h0, L, 32'h0,   L, 32'h0, L));
    step(V(H, L, H, H, 32'h600, L, 32'h0, 32'h0, L, 32'h600, L, 32'h0, L));
    step(V(H, L, H, L, 32'h0,   L, 32'h0, 32'h0, L, 32'h604, L, 32'h0, L));

    if (exp_q.size() != 0) begin
      nmis++;
      $display("FAIL scoreboard: got %0d leftover entries, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
